instr_enc_32: RTL
=================

# instr_enc_32

Pipelined RV32 instruction encoder, the inverse of the immediate generator. It accepts an instruction format, register/function fields and a full 32-bit immediate. It scatters the immediate into the format-specific bit positions and emits a 32-bit instruction word through a valid/ready pipeline. It feeds the debug instruction injector and the self-test program builder, which deliver encoded words into the fetch path.

## Interface
Parameters:
- none; all widths are fixed by RV32.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept this cycle
- instr_type  in  3  format, using the `datatypes.sv` enum: INSTR_R, INSTR_I, INSTR_S, INSTR_B, INSTR_U, INSTR_J
- opcode  in  7  placed at [6:0]
- rd  in  5  placed at [11:7] for R/I/U/J
- funct3  in  3  placed at [14:12] for R/I/S/B
- rs1  in  5  placed at [19:15] for R/I/S/B
- rs2  in  5  placed at [24:20] for R/S/B
- funct7  in  7  placed at [31:25] for R only
- imm  in  32  immediate, in the same representation the immediate generator produces
- out_valid  out  1  instr valid
- out_ready  in  1  downstream accepts
- instr  out  32  encoded word
- imm_err  out  1  immediate not representable in the format (checked build only)
- err_cnt  out  8  saturating count of delivered words with imm_err=1 (checked build only)

## Operation
- Immediate placement:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - R: imm is ignored.
- Fields that a format does not use are not driven from inputs; imm bits occupy those positions.
- Undefined instr_type: instr=32'h0, and imm_err=1 in the checked build.
- Representability checks:
  - I/S: imm[31:11] all equal.
  - B: imm[0]=0 and imm[31:12] all equal.
  - J: imm[0]=0 and imm[31:20] all equal.
  - U: imm[11:0]=0.
  - R: always representable.
- Round-trip invariant: when imm_err=0, the immediate generator applied to instr with the same instr_type returns imm exactly.
- Stage S1 registers all inputs and computes the check. Stage S2 registers instr and imm_err.
  - Each stage has its own valid bit.
  - S2 loads when !s2_valid || out_ready.
  - S1 loads when !s1_valid || S2 loads.
  - in_ready = !s1_valid || S2 loads. This is combinational from out_ready; no bubble.
- Transfer rule: a transfer happens when valid && ready on the same edge. out_valid, instr and imm_err hold stable while out_valid && !out_ready.
- err_cnt increments on each output transfer with imm_err=1 and saturates at 8'hFF.

## Timing
- Reset: s1_valid=0, s2_valid=0, out_valid=0, instr=0, imm_err=0, err_cnt=0. in_ready=1 in the first cycle after reset release.
- Latency: a request accepted at edge N appears with out_valid=1 after edge N+1 (2 cycles).
- Throughput is 1 word/cycle with out_ready held high.
- Back-pressure:
  - With out_ready=0, at most 2 words are held.
  - in_ready falls after the second acceptance.
  - in_ready returns in the same cycle out_ready rises.
- Simultaneous input accept and output transfer in one cycle is legal and loses no data.
- Reset mid-operation discards both stages immediately. No partial word is emitted.

## Configuration
- IMM_CHECK_EN defined:
  - The representability checks run.
  - imm_err and err_cnt behave as described above.
- IMM_CHECK_EN undefined:
  - The check logic and counter are removed.
  - imm_err and err_cnt are tied to 0.
  - Out-of-range immediates are silently truncated to the placed bits.
  - Encoding and timing are otherwise identical.

## Test plan
- I-type: opcode=7'h13, rd=1, rs1=0, funct3=0, imm=5 -> instr=32'h00500093, imm_err=0, out_valid high 2 cycles after acceptance.
- B-type: opcode=7'h63, rs1=0, rs2=0, funct3=0, imm=8 -> instr=32'h00000463.
- J-type: opcode=7'h6F, rd=1, imm=32'hFFFFFFFC -> instr=32'hFFDFF0EF.
- Range error: I-type imm=2048 -> imm_err=1 and err_cnt=1. Repeat 300 times -> err_cnt saturates at 8'hFF. Without IMM_CHECK_EN: imm_err=0 and instr[31:20]=12'h800.
- Back-pressure: hold out_ready=0 and present 3 requests -> 2 accepted and in_ready=0. Raise out_ready -> words emerge in order, with no loss or duplication.
- Async reset: assert rst_n=0 with both stages full -> out_valid=0 immediately and err_cnt=0. After release -> in_ready=1.

Source files
------------

// File: rtl/instr_enc_32.sv
// instr_enc_32: two-stage valid/ready RV32 instruction encoder (immediate scatter, inverse of imm-gen).
// Optional immediate representability checking and error counting: define IMM_CHECK_EN.

package instr_enc_32_pkg;

   typedef enum logic [2:0] {
      INSTR_R = 3'd0,
      INSTR_I = 3'd1,
      INSTR_S = 3'd2,
      INSTR_B = 3'd3,
      INSTR_U = 3'd4,
      INSTR_J = 3'd5
   } instr_type_e;

   typedef struct packed {
      logic [2:0]  itype;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } enc_req_t;

endpackage

module instr_enc_32
   import instr_enc_32_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  instr_type,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] instr,
   output logic        imm_err,
   output logic [7:0]  err_cnt
);

   enc_req_t    s1_req_q, s1_req_d;
   logic        s1_valid_q, s1_valid_d;
   logic        s2_valid_q, s2_valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] enc_word;
   logic        s1_load, s2_load;

   // An empty S2 or a draining output frees S2; S1 then frees behind it in the same cycle.
   assign s2_load   = !s2_valid_q || out_ready;
   assign s1_load   = !s1_valid_q || s2_load;
   assign in_ready  = s1_load;
   assign out_valid = s2_valid_q;
   assign instr     = instr_q;

   always_comb begin : encode
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      enc_word = 32'h0;
      case (s1_req_q.itype)
         INSTR_R: enc_word = {s1_req_q.funct7, s1_req_q.rs2, s1_req_q.rs1,
                              s1_req_q.funct3, s1_req_q.rd, s1_req_q.opcode};
         INSTR_I: enc_word = {s1_req_q.imm[11:0], s1_req_q.rs1,
                              s1_req_q.funct3, s1_req_q.rd, s1_req_q.opcode};
         INSTR_S: enc_word = {s1_req_q.imm[11:5], s1_req_q.rs2, s1_req_q.rs1,
                              s1_req_q.funct3, s1_req_q.imm[4:0], s1_req_q.opcode};
         INSTR_B: enc_word = {s1_req_q.imm[12], s1_req_q.imm[10:5], s1_req_q.rs2,
                              s1_req_q.rs1, s1_req_q.funct3, s1_req_q.imm[4:1],
                              s1_req_q.imm[11], s1_req_q.opcode};
         INSTR_U: enc_word = {s1_req_q.imm[31:12], s1_req_q.rd, s1_req_q.opcode};
         INSTR_J: enc_word = {s1_req_q.imm[20], s1_req_q.imm[10:1], s1_req_q.imm[11],
                              s1_req_q.imm[19:12], s1_req_q.rd, s1_req_q.opcode};
         default: enc_word = 32'h0;
      endcase
   end

   always_comb begin : pipe_next
      s1_valid_d = s1_valid_q;
      s1_req_d   = s1_req_q;
      s2_valid_d = s2_valid_q;
      instr_d    = instr_q;
      if (s1_load) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_req_d = '{itype: instr_type, opcode: opcode, rd: rd, funct3: funct3,
                         rs1: rs1, rs2: rs2, funct7: funct7, imm: imm};
         end
      end
      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            instr_d = enc_word;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : pipe_regs
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_req_q   <= '0;
         s2_valid_q <= 1'b0;
         instr_q    <= 32'h0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         s1_valid_q <= s1_valid_d;
         s1_req_q   <= s1_req_d;
         s2_valid_q <= s2_valid_d;
         instr_q    <= instr_d;
      end
   end

`ifdef IMM_CHECK_EN
   logic       enc_err;
   logic       imm_err_q, imm_err_d;
   logic [7:0] err_cnt_q, err_cnt_d;

   // A field fits when every bit above the top placed bit replicates that bit's sign.
   always_comb begin : check
      enc_err = 1'b0;
      case (s1_req_q.itype)
         INSTR_R: enc_err = 1'b0;
         INSTR_I,
         INSTR_S: enc_err = !((&s1_req_q.imm[31:11]) || !(|s1_req_q.imm[31:11]));
         INSTR_B: enc_err = s1_req_q.imm[0] ||
                            !((&s1_req_q.imm[31:12]) || !(|s1_req_q.imm[31:12]));
         INSTR_U: enc_err = |s1_req_q.imm[11:0];
         INSTR_J: enc_err = s1_req_q.imm[0] ||
                            !((&s1_req_q.imm[31:20]) || !(|s1_req_q.imm[31:20]));
         default: enc_err = 1'b1;
      endcase
   end

   always_comb begin : err_next
      imm_err_d = imm_err_q;
      err_cnt_d = err_cnt_q;
      if (s2_load && s1_valid_q) begin
         imm_err_d = enc_err;
      end
      if (s2_valid_q && out_ready && imm_err_q && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : err_regs
      if (!rst_n) begin
         imm_err_q <= 1'b0;
         err_cnt_q <= 8'h00;
      end else begin
         imm_err_q <= imm_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign imm_err = imm_err_q;
   assign err_cnt = err_cnt_q;
`else
   assign imm_err = 1'b0;
   assign err_cnt = 8'h00;
`endif

endmodule
